uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter comm_clk_frequency, default 50_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter baud_rate, default 115_200, meaning serial bit rate in bit/s.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port uart_rx  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-006 SHALL have port rx_byte  output  8  last correctly framed byte.
REQ-007 SHALL have port rx_new_byte  output  1  one-cycle pulse; rx_byte valid in that cycle and until the next pulse.
REQ-008 SHALL have port rx_frame_error  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 SHALL have port rx_busy  output  1  high from start-bit detection until return to IDLE.

Function
REQ-010 SHALL pass uart_rx through a 2-flop synchronizer, initialised high; all decisions use the synchronized value rx_s.
REQ-011 SHALL use CLKS_PER_BIT = comm_clk_frequency / baud_rate (integer division; 434 at defaults) and HALF_BIT = CLKS_PER_BIT / 2 (217).
REQ-012 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-013 IDLE: rx_s == 0 -> START with bit timer cleared; otherwise remain.
REQ-014 START: at timer == HALF_BIT-1 sample rx_s; 0 -> DATA, timer cleared, bit index 0; 1 -> IDLE (glitch reject, no output pulse).
REQ-015 DATA: at each timer == CLKS_PER_BIT-1 shift rx_s into shift register bit [index], LSB first; after index 7 -> STOP.
REQ-016 STOP: at timer == CLKS_PER_BIT-1 sample rx_s; 1 -> rx_byte <= shift register, rx_new_byte pulsed next cycle, -> IDLE; 0 -> rx_frame_error pulsed next cycle, rx_byte unchanged, -> WAIT_IDLE.
REQ-017 WAIT_IDLE: remain until rx_s == 1, then -> IDLE; no start detection while low (break condition).
REQ-018 Latency: rx_new_byte SHALL assert exactly 2 + HALF_BIT + 9*CLKS_PER_BIT cycles (+1 registered output) after the uart_rx falling edge is presented, within synchronizer alignment of 1 cycle.
REQ-019 Back-to-back frames: a start bit beginning immediately after the stop-bit sample point SHALL be received with no loss (IDLE re-entered ≥ HALF_BIT before next start edge).
REQ-020 rx_new_byte and rx_frame_error SHALL never assert in the same cycle and SHALL each be high for exactly one cycle per frame.
REQ-021 Bit timer width SHALL be $clog2(CLKS_PER_BIT); bit index 3 bits; timer never wraps within a state (cleared on every sample).
REQ-022 Receiver SHALL tolerate ±2% baud mismatch between sender and comm_clk_frequency/baud_rate.

Reset
REQ-023 reset SHALL force: state IDLE, synchronizer flops 1, timer 0, bit index 0, shift register 0, rx_byte 8'h00, rx_new_byte 0, rx_frame_error 0, rx_busy 0.
REQ-024 reset asserted mid-frame SHALL abort the frame with no pulse; after deassertion, reception resumes at the next falling edge seen in IDLE (a line already low at deassertion is treated as a start edge).

Structure
REQ-025 State encodings and the CLKS_PER_BIT/HALF_BIT derivation SHALL live in a shared uart_defs include, also used by uart_transmitter so both ends agree on timing.
REQ-026 The synchronizer SHALL be a separate sub-module sync_2ff (parameterised reset value), reusable for other asynchronous inputs; all else in one module.

Verification
REQ-027 Send 0xA5 at 115200 with defaults -> one rx_new_byte pulse, rx_byte = 8'hA5, rx_frame_error never high, pulse at REQ-018 latency ±1.
REQ-028 Low glitch of 100 cycles on idle line -> rx_busy returns low after 217 cycles, no rx_new_byte, no rx_frame_error.
REQ-029 Frame 0x3C with stop bit 0, then line low 2 bit times, then high, then frame 0x3C valid -> one rx_frame_error pulse, rx_byte still previous value, then rx_new_byte with 8'h3C.
REQ-030 Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three rx_new_byte pulses, values in order.
REQ-031 Assert reset at data bit 4 of 0x81, release, send 0x7E -> no pulse for 0x81, rx_byte = 8'h00 until 0x7E received correctly.
REQ-032 Sender at 115200 × 1.02 and × 0.98, 256 random bytes each -> all received correctly, zero frame errors.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing derivation.
// The transmitter imports the same helpers so both ends agree on timing.
package uart_receiver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int calc_half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input with a configurable
// reset value, so idle-high lines do not look like an edge coming out of reset.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling from a half-bit start qualification,
// registered byte/frame-error pulses and break handling after a bad stop bit.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int comm_clk_frequency = 50_000_000,
  parameter int baud_rate          = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_new_byte,
  output logic       rx_frame_error,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(comm_clk_frequency, baud_rate);
  localparam int HALF_BIT     = calc_half_bit(CLKS_PER_BIT);
  localparam int TIMER_W      = $clog2(CLKS_PER_BIT);

  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(HALF_BIT - 1);
  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);

  logic               rx_s;
  rx_state_e          state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [2:0]         bit_index, bit_index_next;
  logic [7:0]         shift_reg, shift_next;
  logic [7:0]         byte_next;
  logic               new_next, err_next;

  sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (uart_rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      timer          <= '0;
      bit_index      <= '0;
      shift_reg      <= '0;
      rx_byte        <= 8'h00;
      rx_new_byte    <= 1'b0;
      rx_frame_error <= 1'b0;
    end else begin
      state          <= state_next;
      timer          <= timer_next;
      bit_index      <= bit_index_next;
      shift_reg      <= shift_next;
      rx_byte        <= byte_next;
      rx_new_byte    <= new_next;
      rx_frame_error <= err_next;
    end
  end

  // The timer is cleared at every sample point, so it never needs to wrap.
  always_comb begin
    state_next     = state;
    timer_next     = timer;
    bit_index_next = bit_index;
    shift_next     = shift_reg;
    byte_next      = rx_byte;
    new_next       = 1'b0;
    err_next       = 1'b0;

    case (state)
      IDLE: begin
        timer_next = '0;
        if (!rx_s) begin
          state_next = START;
        end
      end

      START: begin
        if (timer == HALF_LAST) begin
          timer_next = '0;
          if (!rx_s) begin
            state_next     = DATA;
            bit_index_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      DATA: begin
        if (timer == BIT_LAST) begin
          timer_next            = '0;
          shift_next[bit_index] = rx_s;
          if (bit_index == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_index_next = bit_index + 3'd1;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      STOP: begin
        if (timer == BIT_LAST) begin
          timer_next = '0;
          if (rx_s) begin
            byte_next  = shift_reg;
            new_next   = 1'b1;
            state_next = IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = WAIT_IDLE;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      WAIT_IDLE: begin
        timer_next = '0;
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver, run at a reduced clock
// (20 clocks per bit) so that the tolerance sweeps stay short.
module tb_uart_receiver;

  localparam int CLK_HZ  = 2_304_000;
  localparam int BAUD    = 115_200;
  localparam int CPB     = 20;
  localparam int HALF    = 10;
  localparam int BIT_NS  = 200;
  localparam int FAST_NS = 196;
  localparam int SLOW_NS = 204;
  localparam int LATENCY = 3 + HALF + 9 * CPB;
  localparam int NRAND   = 64;

  logic       clk;
  logic       reset;
  logic       uart_rx;
  logic [7:0] rx_byte;
  logic       rx_new_byte;
  logic       rx_frame_error;
  logic       rx_busy;

  int vectors     = 0;
  int miscompares = 0;
  int cycle_cnt   = 0;
  int new_cnt     = 0;
  int err_cnt     = 0;
  int overlap_cnt = 0;
  int long_cnt    = 0;
  int last_new_cycle = 0;
  int frame_start    = 0;
  logic [7:0] got[$];
  logic prev_new = 1'b0;
  logic prev_err = 1'b0;

  uart_receiver #(
    .comm_clk_frequency(CLK_HZ),
    .baud_rate         (BAUD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx       (uart_rx),
    .rx_byte       (rx_byte),
    .rx_new_byte   (rx_new_byte),
    .rx_frame_error(rx_frame_error),
    .rx_busy       (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt++;

  // Pulse monitor: sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (rx_new_byte === 1'b1) begin
      new_cnt++;
      got.push_back(rx_byte);
      last_new_cycle = cycle_cnt;
    end
    if (rx_frame_error === 1'b1) err_cnt++;
    if (rx_new_byte === 1'b1 && rx_frame_error === 1'b1) overlap_cnt++;
    if ((rx_new_byte === 1'b1 && prev_new === 1'b1) ||
        (rx_frame_error === 1'b1 && prev_err === 1'b1)) long_cnt++;
    prev_new = rx_new_byte;
    prev_err = rx_frame_error;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_monitor();
    new_cnt = 0;
    err_cnt = 0;
    got.delete();
  endtask

  task automatic send_frame(input logic [7:0] data, input int bit_ns, input logic stop_bit);
    uart_rx     = 1'b0;
    frame_start = cycle_cnt;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      uart_rx = data[i];
      #(bit_ns);
    end
    uart_rx = stop_bit;
    #(bit_ns);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    uart_rx = 1'b1;
    wait_cycles(3);
    vectors++;
    if (rx_byte !== 8'h00) begin
      miscompares++; $display("[TB] FAIL reset_rx_byte: got %h expected %h", rx_byte, 8'h00);
    end
    vectors++;
    if (rx_new_byte !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_new_byte: got %b expected 0", rx_new_byte);
    end
    vectors++;
    if (rx_frame_error !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_frame_error: got %b expected 0", rx_frame_error);
    end
    vectors++;
    if (rx_busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", rx_busy);
    end
    reset = 1'b0;
    wait_cycles(1);
    vectors++;
    if (rx_busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL post_reset_busy_1: got %b expected 0", rx_busy);
    end
    wait_cycles(3);
    vectors++;
    if (rx_busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL post_reset_busy_4: got %b expected 0", rx_busy);
    end
  endtask

  task automatic test_single_byte();
    int lat;
    logic [7:0] first;
    clear_monitor();
    send_frame(8'hA5, BIT_NS, 1'b1);
    wait_cycles(2 * CPB);
    first = (got.size() > 0) ? got[0] : 8'hxx;
    lat   = last_new_cycle - frame_start;
    vectors++;
    if (new_cnt !== 1) begin
      miscompares++; $display("[TB] FAIL single_pulse_count: got %0d expected 1", new_cnt);
    end
    vectors++;
    if (first !== 8'hA5) begin
      miscompares++; $display("[TB] FAIL single_value: got %h expected a5", first);
    end
    vectors++;
    if (err_cnt !== 0) begin
      miscompares++; $display("[TB] FAIL single_frame_error: got %0d expected 0", err_cnt);
    end
    vectors++;
    if (rx_byte !== 8'hA5) begin
      miscompares++; $display("[TB] FAIL single_rx_byte_held: got %h expected a5", rx_byte);
    end
    vectors++;
    if (lat < LATENCY - 1 || lat > LATENCY + 1) begin
      miscompares++; $display("[TB] FAIL single_latency: got %0d expected %0d +/-1", lat, LATENCY);
    end
    vectors++;
    if (rx_busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL single_busy_after: got %b expected 0", rx_busy);
    end
  endtask

  task automatic test_glitch();
    int start;
    int n;
    clear_monitor();
    uart_rx = 1'b0;
    start   = cycle_cnt;
    wait_cycles(4);
    uart_rx = 1'b1;
    vectors++;
    if (rx_busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL glitch_busy_rise: got %b expected 1", rx_busy);
    end
    n = 0;
    while (rx_busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 200 || (cycle_cnt - start) < 3 + HALF - 1 || (cycle_cnt - start) > 3 + HALF + 1) begin
      miscompares++;
      $display("[TB] FAIL glitch_busy_duration: got %0d expected %0d +/-1", cycle_cnt - start, 3 + HALF);
    end
    wait_cycles(3 * CPB);
    vectors++;
    if (new_cnt !== 0) begin
      miscompares++; $display("[TB] FAIL glitch_new_byte: got %0d expected 0", new_cnt);
    end
    vectors++;
    if (err_cnt !== 0) begin
      miscompares++; $display("[TB] FAIL glitch_frame_error: got %0d expected 0", err_cnt);
    end
  endtask

  task automatic test_frame_error();
    logic [7:0] first;
    clear_monitor();
    send_frame(8'h3C, BIT_NS, 1'b0);
    #(2 * BIT_NS);
    vectors++;
    if (rx_busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL ferr_busy_in_break: got %b expected 1", rx_busy);
    end
    vectors++;
    if (err_cnt !== 1) begin
      miscompares++; $display("[TB] FAIL ferr_pulse_count: got %0d expected 1", err_cnt);
    end
    vectors++;
    if (new_cnt !== 0) begin
      miscompares++; $display("[TB] FAIL ferr_new_byte: got %0d expected 0", new_cnt);
    end
    vectors++;
    if (rx_byte !== 8'hA5) begin
      miscompares++; $display("[TB] FAIL ferr_rx_byte_kept: got %h expected a5", rx_byte);
    end
    uart_rx = 1'b1;
    wait_cycles(2 * CPB);
    vectors++;
    if (rx_busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL ferr_busy_recover: got %b expected 0", rx_busy);
    end
    clear_monitor();
    send_frame(8'h3C, BIT_NS, 1'b1);
    wait_cycles(2 * CPB);
    first = (got.size() > 0) ? got[0] : 8'hxx;
    vectors++;
    if (new_cnt !== 1 || first !== 8'h3C) begin
      miscompares++; $display("[TB] FAIL ferr_next_frame: got %0d pulses value %h expected 1 pulse value 3c", new_cnt, first);
    end
    vectors++;
    if (err_cnt !== 0) begin
      miscompares++; $display("[TB] FAIL ferr_next_frame_error: got %0d expected 0", err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals[3];
    logic [7:0] g;
    vals = '{8'h00, 8'hFF, 8'h55};
    clear_monitor();
    for (int i = 0; i < 3; i++) send_frame(vals[i], BIT_NS, 1'b1);
    wait_cycles(2 * CPB);
    vectors++;
    if (new_cnt !== 3) begin
      miscompares++; $display("[TB] FAIL b2b_pulse_count: got %0d expected 3", new_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      g = (got.size() > i) ? got[i] : 8'hxx;
      vectors++;
      if (g !== vals[i]) begin
        miscompares++; $display("[TB] FAIL b2b_value_%0d: got %h expected %h", i, g, vals[i]);
      end
    end
    vectors++;
    if (err_cnt !== 0) begin
      miscompares++; $display("[TB] FAIL b2b_frame_error: got %0d expected 0", err_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] data;
    logic [7:0] first;
    data = 8'h81;
    clear_monitor();
    uart_rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      uart_rx = data[i];
      #(BIT_NS);
    end
    uart_rx = data[4];
    #(BIT_NS / 2);
    reset = 1'b1;
    #(BIT_NS / 2);
    vectors++;
    if (rx_byte !== 8'h00) begin
      miscompares++; $display("[TB] FAIL midreset_rx_byte: got %h expected 00", rx_byte);
    end
    vectors++;
    if (rx_busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL midreset_busy: got %b expected 0", rx_busy);
    end
    for (int i = 5; i < 7; i++) begin
      uart_rx = data[i];
      #(BIT_NS);
    end
    uart_rx = data[7];
    #(BIT_NS / 2);
    reset = 1'b0;
    #(BIT_NS / 2);
    uart_rx = 1'b1;
    #(BIT_NS);
    wait_cycles(2 * CPB);
    vectors++;
    if (new_cnt !== 0 || err_cnt !== 0) begin
      miscompares++; $display("[TB] FAIL midreset_no_pulse: got %0d new %0d err expected 0 0", new_cnt, err_cnt);
    end
    vectors++;
    if (rx_byte !== 8'h00) begin
      miscompares++; $display("[TB] FAIL midreset_rx_byte_idle: got %h expected 00", rx_byte);
    end
    clear_monitor();
    send_frame(8'h7E, BIT_NS, 1'b1);
    wait_cycles(2 * CPB);
    first = (got.size() > 0) ? got[0] : 8'hxx;
    vectors++;
    if (new_cnt !== 1 || first !== 8'h7E) begin
      miscompares++; $display("[TB] FAIL midreset_next_frame: got %0d pulses value %h expected 1 pulse value 7e", new_cnt, first);
    end
    vectors++;
    if (rx_byte !== 8'h7E) begin
      miscompares++; $display("[TB] FAIL midreset_rx_byte_final: got %h expected 7e", rx_byte);
    end
  endtask

  task automatic test_baud_tolerance(input int bit_ns, input string tag);
    logic [7:0] sent[NRAND];
    logic [7:0] g;
    clear_monitor();
    for (int i = 0; i < NRAND; i++) sent[i] = 8'($urandom);
    for (int i = 0; i < NRAND; i++) send_frame(sent[i], bit_ns, 1'b1);
    wait_cycles(3 * CPB);
    vectors++;
    if (new_cnt !== NRAND) begin
      miscompares++; $display("[TB] FAIL %s_pulse_count: got %0d expected %0d", tag, new_cnt, NRAND);
    end
    for (int i = 0; i < NRAND; i++) begin
      g = (got.size() > i) ? got[i] : 8'hxx;
      vectors++;
      if (g !== sent[i]) begin
        miscompares++; $display("[TB] FAIL %s_byte_%0d: got %h expected %h", tag, i, g, sent[i]);
      end
    end
    vectors++;
    if (err_cnt !== 0) begin
      miscompares++; $display("[TB] FAIL %s_frame_error: got %0d expected 0", tag, err_cnt);
    end
  endtask

  initial begin
    reset   = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] tolerance sweep, fast sender");
    test_baud_tolerance(FAST_NS, "fast");
    wait_cycles(2);
    $display("[TB] tolerance sweep, slow sender");
    test_baud_tolerance(SLOW_NS, "slow");
    vectors++;
    if (overlap_cnt !== 0) begin
      miscompares++; $display("[TB] FAIL pulse_overlap: got %0d expected 0", overlap_cnt);
    end
    vectors++;
    if (long_cnt !== 0) begin
      miscompares++; $display("[TB] FAIL pulse_width: got %0d multi-cycle pulses expected 0", long_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
